// File: rtl/analog_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : analog_ramp_ctrl
// Brief    : Multi-channel saturating ramp counters that turn held direction
//            buttons into analog-style control values. Define
//            ANALOG_RAMP_ACCEL_EN to enable hold-to-accelerate stepping.
// Revision : 1.0 - initial release
// ============================================================================
module analog_ramp_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 23529,
    parameter int MAX_VAL     = 254,
    parameter int CENTER      = 0,
    parameter int RESET_VAL   = 0,
    parameter int ACCEL_TICKS = 16,
    parameter int ACCEL_STEP  = 4
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS-1:0]       spring,
    input  logic                      preset,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min,
    output logic                      tick
);

    localparam int                 c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0]    c_TERM     = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0]    c_P_ONE    = c_PW'(1);
    localparam logic [WIDTH:0]     c_MAX_X    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0]   c_MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]   c_CENTER_W = WIDTH'(CENTER);
    localparam logic [WIDTH-1:0]   c_RESET_W  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0]   c_ONE_W    = WIDTH'(1);
    localparam logic [WIDTH:0]     c_STEP1    = (WIDTH+1)'(1);
`ifdef ANALOG_RAMP_ACCEL_EN
    localparam int                 c_HW       = $clog2(ACCEL_TICKS + 1);
    localparam logic [c_HW-1:0]    c_HMAX     = c_HW'(ACCEL_TICKS);
    localparam logic [c_HW-1:0]    c_H_ONE    = c_HW'(1);
    localparam logic [WIDTH:0]     c_STEPA    = (WIDTH+1)'(ACCEL_STEP);
`endif

    logic [c_PW-1:0] r_presc;
    logic            r_tick;
    logic            w_term;

    // Shared prescaler; the terminal count is the only cycle inputs are sampled.
    assign w_term = (r_presc == c_TERM);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_term ? '0 : r_presc + c_P_ONE;
            r_tick  <= w_term;
        end
    end

    assign tick = r_tick;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_val;
        logic [WIDTH-1:0] w_next;
        logic [WIDTH:0]   w_ext;
        logic [WIDTH:0]   w_step;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_diff;

`ifdef ANALOG_RAMP_ACCEL_EN
        logic [c_HW-1:0]  r_hold;
        logic [1:0]       r_dir;
        logic [1:0]       w_dir;

        // Direction code: 01 = up only, 10 = down only, 00 = none or both.
        assign w_dir  = (up[i] & ~down[i]) ? 2'b01 :
                        (down[i] & ~up[i]) ? 2'b10 : 2'b00;
        assign w_step = ((r_hold == c_HMAX) && (w_dir == r_dir)) ? c_STEPA : c_STEP1;

        // r_hold counts consecutive same-direction steps already taken.
        always_ff @(posedge clk_sys) begin
            if (reset || preset) begin
                r_hold <= '0;
                r_dir  <= 2'b00;
            end else if (w_term) begin
                if (w_dir == 2'b00) begin
                    r_hold <= '0;
                    r_dir  <= 2'b00;
                end else if (w_dir == r_dir) begin
                    r_hold <= (r_hold == c_HMAX) ? r_hold : r_hold + c_H_ONE;
                end else begin
                    r_hold <= c_H_ONE;
                    r_dir  <= w_dir;
                end
            end
        end
`else
        assign w_step = c_STEP1;
`endif

        // One extra bit of headroom so add/sub never wraps before clamping.
        always_comb begin
            w_ext  = {1'b0, r_val};
            w_sum  = w_ext + w_step;
            w_diff = w_ext - w_step;
            w_next = r_val;
            case ({up[i], down[i]})
                2'b10: w_next = (w_sum > c_MAX_X) ? c_MAX_W : w_sum[WIDTH-1:0];
                2'b01: w_next = (w_ext < w_step) ? '0 : w_diff[WIDTH-1:0];
                2'b00: begin
                    if (spring[i]) begin
                        if (r_val > c_CENTER_W)
                            w_next = r_val - c_ONE_W;
                        else if (r_val < c_CENTER_W)
                            w_next = r_val + c_ONE_W;
                    end
                end
                default: w_next = r_val;
            endcase
        end

        always_ff @(posedge clk_sys) begin
            if (reset)
                r_val <= c_RESET_W;
            else if (preset)
                r_val <= c_CENTER_W;
            else if (w_term)
                r_val <= w_next;
        end

        assign value[i*WIDTH +: WIDTH] = r_val;
        assign at_max[i]               = (r_val == c_MAX_W);
        assign at_min[i]               = (r_val == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_analog_ramp_ctrl.sv
`default_nettype none
// Directed bench for analog_ramp_ctrl with a per-tick expected-value scoreboard.
module tb_analog_ramp_ctrl;

    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int TD   = 4;
    localparam int MAXV = 254;
    localparam int CEN  = 128;
    localparam int RV   = 0;
    localparam int AT   = 16;
    localparam int AS   = 4;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [CH-1:0] up      = '0;
    logic [CH-1:0] down    = '0;
    logic [CH-1:0] spring  = '0;
    logic          preset  = 1'b0;
    logic [CH*W-1:0] value;
    logic [CH-1:0] at_max;
    logic [CH-1:0] at_min;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    int m_val [CH];
    int m_cnt [CH];
    int m_dir [CH];

    typedef struct { int v0; int v1; } exp_t;
    exp_t sb[$];

    always #5 clk_sys = ~clk_sys;

    analog_ramp_ctrl #(
        .CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .MAX_VAL(MAXV),
        .CENTER(CEN), .RESET_VAL(RV), .ACCEL_TICKS(AT), .ACCEL_STEP(AS)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .up(up), .down(down),
        .spring(spring), .preset(preset), .value(value),
        .at_max(at_max), .at_min(at_min), .tick(tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model_clear(input int v);
        for (int c = 0; c < CH; c++) begin
            m_val[c] = v;
            m_cnt[c] = 0;
            m_dir[c] = 0;
        end
    endtask

    task automatic model_tick(input logic [CH-1:0] u, input logic [CH-1:0] d,
                              input logic [CH-1:0] s);
        for (int c = 0; c < CH; c++) begin
            int dir;
            int st;
            dir = (u[c] && !d[c]) ? 1 : ((d[c] && !u[c]) ? 2 : 0);
            st  = 1;
`ifdef ANALOG_RAMP_ACCEL_EN
            if (dir != 0 && dir == m_dir[c] && m_cnt[c] == AT) st = AS;
`endif
            if (dir == 1)
                m_val[c] = (m_val[c] + st > MAXV) ? MAXV : m_val[c] + st;
            else if (dir == 2)
                m_val[c] = (m_val[c] < st) ? 0 : m_val[c] - st;
            else if (!u[c] && !d[c] && s[c]) begin
                if (m_val[c] > CEN) m_val[c]--;
                else if (m_val[c] < CEN) m_val[c]++;
            end
            if (dir == 0) begin
                m_cnt[c] = 0;
                m_dir[c] = 0;
            end else if (dir == m_dir[c]) begin
                m_cnt[c] = (m_cnt[c] < AT) ? m_cnt[c] + 1 : AT;
            end else begin
                m_cnt[c] = 1;
                m_dir[c] = dir;
            end
        end
    endtask

    // Called in the cycle right after a tick (prescaler at 0); waits for the next tick.
    task automatic do_tick(input logic [CH-1:0] u, input logic [CH-1:0] d,
                           input logic [CH-1:0] s, input string tag);
        int   n;
        exp_t e;
        up     = u;
        down   = d;
        spring = s;
        model_tick(u, d, s);
        sb.push_back('{m_val[0], m_val[1]});
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick !== 1'b1 && n < 3*TD);
        chk({tag, "_period"}, n, TD);
        e = sb.pop_front();
        chk({tag, "_v0"}, value[W-1:0], e.v0);
        chk({tag, "_v1"}, value[2*W-1:W], e.v1);
    endtask

    initial begin
        int guard;
        model_clear(RV);

        // Reset state
        cyc();
        cyc();
        chk("rst_v0", value[W-1:0], RV);
        chk("rst_v1", value[2*W-1:W], RV);
        chk("rst_tick", tick, 0);
        chk("rst_at_min", at_min, 2'b11);
        chk("rst_at_max", at_max, 2'b00);
        reset = 1'b0;

        // First ramp step: tick 4 cycles after release, value[0]=1
        do_tick(2'b01, 2'b00, 2'b00, "first");

        // Upper saturation then lower saturation
        repeat (299) do_tick(2'b01, 2'b00, 2'b00, "sat_up");
        chk("sat_up_val", value[W-1:0], MAXV);
        chk("sat_up_at_max", at_max[0], 1);
        repeat (300) do_tick(2'b00, 2'b01, 2'b00, "sat_dn");
        chk("sat_dn_val", value[W-1:0], 0);
        chk("sat_dn_at_min", at_min[0], 1);

        // Pulse up only in a non-terminal cycle: no effect
        up = 2'b01;
        cyc();
        up = 2'b00;
        cyc();
        chk("short_tick_low", tick, 0);
        cyc();
        cyc();
        chk("short_tick", tick, 1);
        chk("short_v0", value[W-1:0], 0);
        model_tick(2'b00, 2'b00, 2'b00);

        // Up and down together hold
        repeat (2) do_tick(2'b11, 2'b11, 2'b00, "both");

        // Preset in the terminal cycle, with up held, wins over the step
        cyc();
        cyc();
        cyc();
        up     = 2'b01;
        preset = 1'b1;
        cyc();
        preset = 1'b0;
        up     = 2'b00;
        chk("preset_tick", tick, 1);
        chk("preset_v0", value[W-1:0], CEN);
        chk("preset_v1", value[2*W-1:W], CEN);
        model_clear(CEN);
        do_tick(2'b00, 2'b00, 2'b00, "post_preset");

        // Spring return on channel 1 from 131
        repeat (3) do_tick(2'b10, 2'b00, 2'b00, "to131");
        chk("to131_val", value[2*W-1:W], 131);
        repeat (5) do_tick(2'b00, 2'b00, 2'b10, "spring");
        chk("spring_center", value[2*W-1:W], CEN);
        repeat (3) do_tick(2'b10, 2'b00, 2'b00, "back131");
        repeat (3) do_tick(2'b00, 2'b00, 2'b00, "nospring");
        chk("nospring_hold", value[2*W-1:W], 131);

        // Walk channel 0 down to 50 with tap-release pairs
        guard = 0;
        while (m_val[0] > 50 && guard < 200) begin
            do_tick(2'b00, 2'b01, 2'b00, "tap_dn");
            do_tick(2'b00, 2'b00, 2'b00, "tap_rel");
            guard++;
        end
        chk("at50", value[W-1:0], 50);

        // Reset in the terminal cycle aborts the step
        cyc();
        cyc();
        cyc();
        down  = 2'b01;
        reset = 1'b1;
        cyc();
        chk("midrst_v0", value[W-1:0], RV);
        chk("midrst_v1", value[2*W-1:W], RV);
        chk("midrst_tick", tick, 0);
        reset = 1'b0;
        down  = 2'b00;
        model_clear(RV);
        do_tick(2'b00, 2'b00, 2'b00, "after_rst");

`ifdef ANALOG_RAMP_ACCEL_EN
        // Acceleration: 16 unit steps, then ACCEL_STEP per tick
        repeat (16) do_tick(2'b01, 2'b00, 2'b00, "acc_slow");
        chk("acc_16", value[W-1:0], 16);
        do_tick(2'b01, 2'b00, 2'b00, "acc_fast1");
        chk("acc_20", value[W-1:0], 20);
        do_tick(2'b01, 2'b00, 2'b00, "acc_fast2");
        chk("acc_24", value[W-1:0], 24);
        do_tick(2'b00, 2'b00, 2'b00, "acc_rel");
        do_tick(2'b01, 2'b00, 2'b00, "acc_restart");
        chk("acc_25", value[W-1:0], 25);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
